// File: rtl/sampled_phase_frequency_detector.sv
// sampled_phase_frequency_detector
//
// Multi-channel sampled phase/frequency detector. Each channel compares a
// reference clock and a divided feedback clock. Both clocks are already
// synchronous to clk. Each channel drives charge-pump up/down requests and
// measures the phase error in clk cycles.
//
// Optional feature: define PFD_LOCK_DETECT_EN to build the per-channel lock
// detector. Without it, locked is tied low.
//
// Ports
//   clk                            system clock, rising edge
//   reset_n                        asynchronous active-low reset
//   enable                         1 = detectors run, 0 = channels held idle
//   input_reference_clock_digital  [NUM_CHANNELS] reference clocks
//   input_feedback_clock_digital   [NUM_CHANNELS] feedback clocks
//   output_up_digital              [NUM_CHANNELS] charge-pump up requests
//   output_down_digital            [NUM_CHANNELS] charge-pump down requests
//   phase_error                    [NUM_CHANNELS*ERR_WIDTH] signed errors,
//                                  channel i at [i*ERR_WIDTH +: ERR_WIDTH]
//   error_valid                    [NUM_CHANNELS] one-cycle capture strobes
//   locked                         [NUM_CHANNELS] lock indications
module sampled_phase_frequency_detector #(
  parameter int NUM_CHANNELS     = 1,
  parameter int MIN_PULSE_CYCLES = 2,
  parameter int ERR_WIDTH        = 8,
  parameter int LOCK_WINDOW      = 2,
  parameter int LOCK_COUNT       = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [NUM_CHANNELS-1:0]           input_reference_clock_digital,
  input  logic [NUM_CHANNELS-1:0]           input_feedback_clock_digital,
  output logic [NUM_CHANNELS-1:0]           output_up_digital,
  output logic [NUM_CHANNELS-1:0]           output_down_digital,
  output logic [NUM_CHANNELS*ERR_WIDTH-1:0] phase_error,
  output logic [NUM_CHANNELS-1:0]           error_valid,
  output logic [NUM_CHANNELS-1:0]           locked
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_BOTH} state_t;

  localparam logic signed [ERR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [7:0] PULSE_LAST = 8'(MIN_PULSE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic                        ref_hist_q, fb_hist_q;
      logic                        ref_edge, fb_edge;
      state_t                      state_q, state_d;
      logic signed [ERR_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
      logic [7:0]                  pulse_q, pulse_d;
      logic signed [ERR_WIDTH-1:0] err_q, capture_val;
      logic                        valid_q, capture;
      logic                        up_c, down_c;
      logic                        locked_q;

      assign ref_edge = input_reference_clock_digital[gi] & ~ref_hist_q;
      assign fb_edge  = input_feedback_clock_digital[gi]  & ~fb_hist_q;

      // Saturating step values.
      assign cnt_inc = (cnt_q == ERR_MAX) ? cnt_q : cnt_q + 1'b1;
      assign cnt_dec = (cnt_q == ERR_MIN) ? cnt_q : cnt_q - 1'b1;

      // State register and datapath registers.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ref_hist_q <= 1'b0;
          fb_hist_q  <= 1'b0;
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          pulse_q    <= '0;
          err_q      <= '0;
          valid_q    <= 1'b0;
        end else begin
          ref_hist_q <= input_reference_clock_digital[gi];
          fb_hist_q  <= input_feedback_clock_digital[gi];
          state_q    <= state_d;
          cnt_q      <= cnt_d;
          pulse_q    <= pulse_d;
          valid_q    <= capture;
          if (capture) err_q <= capture_val;
        end
      end

      // Next-state logic. A capture marks every transition into BOTH.
      always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        capture_val = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          unique case (state_q)
            S_IDLE: begin
              if (ref_edge && fb_edge) begin
                state_d = S_BOTH;
                capture = 1'b1;
              end else if (ref_edge) begin
                state_d = S_UP;
              end else if (fb_edge) begin
                state_d = S_DOWN;
              end
            end
            // The capture cycle itself still counts toward the error.
            S_UP: begin
              if (fb_edge) begin
                state_d     = S_BOTH;
                capture     = 1'b1;
                capture_val = cnt_inc;
              end
            end
            S_DOWN: begin
              if (ref_edge) begin
                state_d     = S_BOTH;
                capture     = 1'b1;
                capture_val = cnt_dec;
              end
            end
            S_BOTH: begin
              if (pulse_q == PULSE_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      // The error counter runs only in UP or DOWN. It is zero at every other
      // time, so it restarts from 0 each time the channel leaves IDLE.
      always_comb begin
        cnt_d   = '0;
        pulse_d = '0;
        if (enable) begin
          if (state_q == S_UP && !capture)   cnt_d = cnt_inc;
          if (state_q == S_DOWN && !capture) cnt_d = cnt_dec;
          if (state_q == S_BOTH)             pulse_d = pulse_q + 8'd1;
        end
      end

      // Output decode from registered state only.
      always_comb begin
        up_c   = (state_q == S_UP)   || (state_q == S_BOTH);
        down_c = (state_q == S_DOWN) || (state_q == S_BOTH);
      end

`ifdef PFD_LOCK_DETECT_EN
      localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
      logic [STREAK_W-1:0]  streak_q;
      logic [ERR_WIDTH-1:0] err_mag;
      logic                 in_window;

      // The magnitude is unsigned, so the most negative error fits in the word.
      assign err_mag   = capture_val[ERR_WIDTH-1] ? ERR_WIDTH'(-capture_val)
                                                  : ERR_WIDTH'(capture_val);
      assign in_window = (32'(err_mag) <= 32'(LOCK_WINDOW));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          streak_q <= '0;
          locked_q <= 1'b0;
        end else if (capture) begin
          if (in_window) begin
            if (32'(streak_q) < 32'(LOCK_COUNT)) streak_q <= streak_q + 1'b1;
            if (32'(streak_q) + 32'd1 >= 32'(LOCK_COUNT)) locked_q <= 1'b1;
          end else begin
            streak_q <= '0;
            locked_q <= 1'b0;
          end
        end
      end
`else
      assign locked_q = 1'b0;
`endif

      assign output_up_digital[gi]               = up_c;
      assign output_down_digital[gi]             = down_c;
      assign phase_error[gi*ERR_WIDTH +: ERR_WIDTH] = err_q;
      assign error_valid[gi]                     = valid_q;
      assign locked[gi]                          = locked_q;
    end
  endgenerate

endmodule

// File: tb/tb_sampled_phase_frequency_detector.sv
module tb_sampled_phase_frequency_detector;

  localparam int NCH  = 2;
  localparam int MINP = 2;
  localparam int EW   = 8;
  localparam int LW   = 2;
  localparam int LC   = 8;
`ifdef PFD_LOCK_DETECT_EN
  localparam int LOCK_EN = 1;
`else
  localparam int LOCK_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [NCH-1:0]    ref_in = '0;
  logic [NCH-1:0]    fb_in = '0;
  logic [NCH-1:0]    up_o, down_o, ev_o, lock_o;
  logic [NCH*EW-1:0] pe_o;

  always #5 clk = ~clk;

  sampled_phase_frequency_detector #(
    .NUM_CHANNELS(NCH), .MIN_PULSE_CYCLES(MINP), .ERR_WIDTH(EW),
    .LOCK_WINDOW(LW), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .input_reference_clock_digital(ref_in),
    .input_feedback_clock_digital(fb_in),
    .output_up_digital(up_o), .output_down_digital(down_o),
    .phase_error(pe_o), .error_valid(ev_o), .locked(lock_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model. It is event based: it remembers which clock led and the
  // cycle of that edge. The error is the difference between edge times,
  // clamped to the word range.
  int n = 0;
  int m_lead[NCH];    // 0 none, +1 reference leads, -1 feedback leads
  int m_cyc[NCH];     // cycle of the leading edge
  int m_hold[NCH];    // remaining both-high cycles
  int m_pe[NCH];
  int m_ev[NCH];
  int m_streak[NCH];
  int m_lock[NCH];
  bit m_rh[NCH];
  bit m_fh[NCH];

  function automatic int clampe(input int v);
    int hi = (1 << (EW - 1)) - 1;
    int lo = -(1 << (EW - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lead[c] = 0; m_cyc[c] = 0; m_hold[c] = 0; m_pe[c] = 0; m_ev[c] = 0;
      m_streak[c] = 0; m_lock[c] = 0; m_rh[c] = 0; m_fh[c] = 0;
    end
  endtask

  task automatic model_capture(input int c, input int e);
    int mag;
    m_pe[c] = e; m_ev[c] = 1; m_lead[c] = 0; m_hold[c] = MINP;
    $display("capture ch%0d cycle %0d error %0d", c, n, e);
    if (LOCK_EN != 0) begin
      mag = (e < 0) ? -e : e;
      if (mag <= LW) begin
        m_streak[c]++;
        if (m_streak[c] >= LC) m_lock[c] = 1;
      end else begin
        m_streak[c] = 0;
        m_lock[c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    bit re, fe;
    n++;
    for (int c = 0; c < NCH; c++) begin
      re = ref_in[c] && !m_rh[c];
      fe = fb_in[c] && !m_fh[c];
      m_rh[c] = ref_in[c];
      m_fh[c] = fb_in[c];
      m_ev[c] = 0;
      if (!enable) begin
        m_lead[c] = 0; m_hold[c] = 0;
      end else if (m_hold[c] > 0) begin
        m_hold[c]--;
      end else if (m_lead[c] == 0) begin
        if (re && fe)  model_capture(c, 0);
        else if (re) begin m_lead[c] = 1;  m_cyc[c] = n; end
        else if (fe) begin m_lead[c] = -1; m_cyc[c] = n; end
      end else if (m_lead[c] == 1) begin
        if (fe) model_capture(c, clampe(n - m_cyc[c]));
      end else begin
        if (re) model_capture(c, clampe(m_cyc[c] - n));
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("up%0d@%0d", c, n),   int'(up_o[c]),   int'(m_lead[c] == 1 || m_hold[c] > 0));
      chk($sformatf("down%0d@%0d", c, n), int'(down_o[c]), int'(m_lead[c] == -1 || m_hold[c] > 0));
      chk($sformatf("ev%0d@%0d", c, n),   int'(ev_o[c]),   m_ev[c]);
      chk($sformatf("pe%0d@%0d", c, n),   int'($signed(pe_o[c*EW +: EW])), m_pe[c]);
      chk($sformatf("lock%0d@%0d", c, n), int'(lock_o[c]), m_lock[c]);
    end
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // then compare at the next falling edge.
  task automatic step(input logic [1:0] r, input logic [1:0] f, input logic en);
    ref_in = r; fb_in = f; enable = en;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic zeros(input int k);
    for (int i = 0; i < k; i++) step(2'b00, 2'b00, 1'b1);
  endtask

  // Assert reset between clock edges; outputs must drop without a clock.
  task automatic async_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_up", int'(up_o), 0);
    chk("rst_down", int'(down_o), 0);
    chk("rst_ev", int'(ev_o), 0);
    chk("rst_pe", int'(pe_o), 0);
    chk("rst_lock", int'(lock_o), 0);
    model_reset();
    ref_in = '0; fb_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_up", int'(up_o), 0);
    chk("reset_down", int'(down_o), 0);
    chk("reset_pe", int'(pe_o), 0);
    chk("reset_ev", int'(ev_o), 0);
    chk("reset_lock", int'(lock_o), 0);
    reset_n = 1'b1;

    // Reference leads feedback by 3 cycles on ch0.
    step(2'b01, 2'b00, 1'b1);
    zeros(2);
    step(2'b00, 2'b01, 1'b1);
    chk("lead3_pe", int'($signed(pe_o[7:0])), 3);
    chk("lead3_ev", int'(ev_o[0]), 1);
    chk("lead3_both", int'(up_o[0] & down_o[0]), 1);
    zeros(3);

    // Feedback leads reference by 5 cycles on ch1.
    step(2'b00, 2'b10, 1'b1);
    zeros(4);
    step(2'b10, 2'b00, 1'b1);
    chk("lag5_pe", int'($signed(pe_o[15:8])), -5);
    chk("lag5_ch0", int'(up_o[0] | down_o[0]), 0);
    zeros(3);

    // Coincident edges on both channels.
    step(2'b11, 2'b11, 1'b1);
    chk("same_pe", int'(pe_o), 0);
    chk("same_both", int'(up_o & down_o), 3);
    zeros(3);

    // Cycle slipping: ref toggles, feedback stays low until the end.
    for (int i = 0; i < 300; i++) step({1'b0, (i % 2) == 0}, 2'b00, 1'b1);
    step(2'b00, 2'b01, 1'b1);
    chk("sat_pe", int'($signed(pe_o[7:0])), 127);
    zeros(3);

    // Lock detector: 8 captures of +1, then one of +4.
    async_reset();
    for (int k = 0; k < LC; k++) begin
      step(2'b01, 2'b00, 1'b1);
      step(2'b00, 2'b01, 1'b1);
      if (k == LC - 1) chk("lock_rise", int'(lock_o[0]), LOCK_EN);
      zeros(3);
    end
    step(2'b01, 2'b00, 1'b1);
    zeros(3);
    step(2'b00, 2'b01, 1'b1);
    chk("lock_fall", int'(lock_o[0]), 0);
    zeros(3);

    // Enable drop in the middle of an up pulse.
    step(2'b01, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b0);
    chk("en_idle", int'(up_o[0]), 0);
    zeros(3);

    // Reset during the both-high pulse aborts without a capture.
    step(2'b11, 2'b11, 1'b1);
    async_reset();
    zeros(2);

    // Randomized traffic with occasional enable drops.
    for (int i = 0; i < 3000; i++) begin
      step({2{1'b0}} | {logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 5) == 0)},
           {logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 5) == 0)},
           logic'($urandom_range(0, 63) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sampled_phase_frequency_detector.md
SAMPLED_PHASE_FREQUENCY_DETECTOR -- requirements
Module: sampled_phase_frequency_detector

Interface
REQ-001 Parameter NUM_CHANNELS, default 1: number of independent detector channels, range 1 to 16.
REQ-002 Parameter MIN_PULSE_CYCLES, default 2: cycles up and down are held together before clearing (anti-dead-zone), range 1 to 255.
REQ-003 Parameter ERR_WIDTH, default 8: two's-complement width of each phase-error word, range 4 to 16.
REQ-004 Parameter LOCK_WINDOW, default 2: maximum magnitude of a captured error that counts as in-lock.
REQ-005 Parameter LOCK_COUNT, default 8: consecutive in-window captures required to declare lock.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  high = detectors run; low = all channels held idle.
REQ-009 input_reference_clock_digital  input  NUM_CHANNELS  per-channel reference clock, already synchronous to clk.
REQ-010 input_feedback_clock_digital  input  NUM_CHANNELS  per-channel divided feedback clock, already synchronous to clk.
REQ-011 output_up_digital  output  NUM_CHANNELS  per-channel charge-pump up request.
REQ-012 output_down_digital  output  NUM_CHANNELS  per-channel charge-pump down request.
REQ-013 phase_error  output  NUM_CHANNELS*ERR_WIDTH  per-channel signed error from the last completed comparison; channel i occupies bits [i*ERR_WIDTH +: ERR_WIDTH].
REQ-014 error_valid  output  NUM_CHANNELS  one-cycle pulse when the channel's phase_error updates.
REQ-015 locked  output  NUM_CHANNELS  per-channel lock indication.

Function
REQ-016 Edge detection: a rising edge is defined as the input sampled 1 at the current clk edge and 0 at the previous clk edge; one history flop per input.
REQ-017 Per-channel FSM has states IDLE, UP, DOWN and BOTH; output_up_digital = state in {UP, BOTH}; output_down_digital = state in {DOWN, BOTH}; outputs decode registered state only.
REQ-018 IDLE: ref edge alone -> UP; fb edge alone -> DOWN; both edges on the same clk edge -> BOTH with error 0.
REQ-019 UP: fb edge -> BOTH; a further ref edge -> remains UP (cycle slip; count continues).
REQ-020 DOWN: ref edge -> BOTH; a further fb edge -> remains DOWN.
REQ-021 BOTH: both outputs high for exactly MIN_PULSE_CYCLES cycles, then IDLE; edges arriving during BOTH are discarded.
REQ-022 Latency: an edge detected at clk edge k changes the outputs immediately after edge k (1 cycle from input sample).
REQ-023 Error counter: starts at 0 on leaving IDLE, +1 per cycle in UP, -1 per cycle in DOWN; saturates at +(2^(ERR_WIDTH-1)-1) and -2^(ERR_WIDTH-1), no wrap.
REQ-024 On entry to BOTH, the counter value is copied to phase_error and error_valid pulses high for that one cycle; the counter then clears.
REQ-025 enable low forces every FSM to IDLE and clears the counters at the next clk edge; phase_error and locked are held; history flops keep sampling.
REQ-026 Channels are fully independent; no cross-channel interaction.

Reset
REQ-027 reset_n low asynchronously sets all FSMs to IDLE, history flops to 0, counters, phase_error, error_valid and locked to 0; outputs up/down 0.
REQ-028 Reset assertion mid-pulse, including in BOTH, aborts immediately; no error capture occurs.

Configuration
REQ-029 Macro PFD_LOCK_DETECT_EN defined: per channel, a capture with |phase_error| <= LOCK_WINDOW increments a streak counter, any other capture clears it and deasserts locked; locked asserts on the capture that brings the streak to LOCK_COUNT and holds until an out-of-window capture.
REQ-030 Macro undefined: no streak logic is instantiated and locked is tied to 0.

Verification (NUM_CHANNELS=2, MIN_PULSE_CYCLES=2, ERR_WIDTH=8)
REQ-031 Ch0 ref edge at cycle 10, fb edge at cycle 13 -> up high cycles 11-15, down high 14-15, phase_error[7:0]=+3, error_valid pulses at cycle 14.
REQ-032 Ch1 fb leads ref by 5 cycles -> down-only for 5 cycles, then both for 2, phase_error[15:8]=-5; ch0 is undisturbed.
REQ-033 Ref and fb edges on the same cycle -> both outputs high for exactly 2 cycles, phase_error=0.
REQ-034 Ref toggling with fb held low for 300 cycles, then one fb edge -> phase_error saturates at +127.
REQ-035 With PFD_LOCK_DETECT_EN, 8 captures of +1 -> locked rises on the 8th; one capture of +4 -> locked falls; without the macro, locked stays 0.
REQ-036 reset_n pulsed low during BOTH -> all outputs 0 asynchronously, no error_valid; enable low mid-UP -> IDLE at next edge.
